// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite responder backed by a small word-addressed register memory.
// Independent AW/W acceptance, byte-strobe writes, one outstanding read and one outstanding write.
module axi_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_WORDS  = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_HAVE_A = 2'd1, W_HAVE_D = 2'd2, W_RESP = 2'd3} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] ax;
    ax = 32'(a);
    in_window = (ax >= 32'(BASE_ADDR)) && (ax < (32'(BASE_ADDR) + 32'(4 * NUM_WORDS)));
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    word_index = IDX_W'((32'(a) - 32'(BASE_ADDR)) >> 2);
  endfunction

  w_state_t w_state_r, w_next_s;
  r_state_t r_state_r, r_next_s;

  logic awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic awready_next_s, wready_next_s, bvalid_next_s, arready_next_s, rvalid_next_s;
  logic [RESP_WIDTH-1:0] bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [NB-1:0]         wstrb_r;
  logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];

  logic aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0] c_addr_s;
  logic [DATA_WIDTH-1:0] c_data_s;
  logic [NB-1:0]         c_strb_s;
  logic                  unused_s;

  assign aw_hs_s  = s_axi_awvalid & awready_r;
  assign w_hs_s   = s_axi_wvalid & wready_r;
  assign ar_hs_s  = s_axi_arvalid & arready_r;
  assign unused_s = s_axi_wstrb[NB];

  // State and handshake-output registers; readies stay low while reset is held
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      r_state_r <= r_next_s;
      awready_r <= awready_next_s;
      wready_r  <= wready_next_s;
      bvalid_r  <= bvalid_next_s;
      arready_r <= arready_next_s;
      rvalid_r  <= rvalid_next_s;
    end
  end

  // Next-state logic for both channels
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) w_next_s = W_RESP;
        else if (aw_hs_s)      w_next_s = W_HAVE_A;
        else if (w_hs_s)       w_next_s = W_HAVE_D;
        else                   w_next_s = W_IDLE;
      end
      W_HAVE_A: if (w_hs_s)  w_next_s = W_RESP; else w_next_s = W_HAVE_A;
      W_HAVE_D: if (aw_hs_s) w_next_s = W_RESP; else w_next_s = W_HAVE_D;
      W_RESP:   if (bvalid_r && s_axi_bready) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default:  w_next_s = W_IDLE;
    endcase
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA:  if (rvalid_r && s_axi_rready) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs are registered
  always_comb begin
    awready_next_s = 1'b0;
    wready_next_s  = 1'b0;
    bvalid_next_s  = 1'b0;
    case (w_next_s)
      W_IDLE:   begin awready_next_s = 1'b1; wready_next_s = 1'b1; end
      W_HAVE_A: wready_next_s  = 1'b1;
      W_HAVE_D: awready_next_s = 1'b1;
      W_RESP:   bvalid_next_s  = 1'b1;
      default:  bvalid_next_s  = 1'b0;
    endcase
    arready_next_s = (r_next_s == R_IDLE);
    rvalid_next_s  = (r_next_s == R_DATA);
  end

  // The commit takes whichever half was latched earlier and the other half from the bus
  always_comb begin
    commit_s = (w_state_r != W_RESP) && (w_next_s == W_RESP);
    if (w_state_r == W_HAVE_A) c_addr_s = aw_addr_r; else c_addr_s = s_axi_awaddr;
    if (w_state_r == W_HAVE_D) begin
      c_data_s = wdata_r;
      c_strb_s = wstrb_r;
    end else begin
      c_data_s = s_axi_wdata;
      c_strb_s = s_axi_wstrb[NB-1:0];
    end
  end

  // Write-side latches, memory array and write response
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_addr_r <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {NB{1'b0}};
      bresp_r   <= RESP_OKAY;
      for (int i = 0; i < NUM_WORDS; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      if (aw_hs_s) aw_addr_r <= s_axi_awaddr;
      if (w_hs_s) begin
        wdata_r <= s_axi_wdata;
        wstrb_r <= s_axi_wstrb[NB-1:0];
      end
      if (commit_s) begin
        if (in_window(c_addr_s)) begin
          bresp_r <= RESP_OKAY;
          for (int b = 0; b < NB; b++)
            if (c_strb_s[b]) mem_r[word_index(c_addr_s)][8*b +: 8] <= c_data_s[8*b +: 8];
        end else begin
          bresp_r <= RESP_SLVERR;
        end
      end
    end
  end

  // Read payload; sampling the array here returns the pre-write word on a same-edge commit
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
      rresp_r <= RESP_OKAY;
    end else if (ar_hs_s) begin
      if (in_window(s_axi_araddr)) begin
        rdata_r <= mem_r[word_index(s_axi_araddr)];
        rresp_r <= RESP_OKAY;
      end else begin
        rdata_r <= {DATA_WIDTH{1'b0}};
        rresp_r <= RESP_SLVERR;
      end
    end else begin
      rdata_r <= rdata_r;
      rresp_r <= rresp_r;
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed self-checking bench for axi_lite_mem_slave (default parameters: 16 words at base 0).
module tb_axi_lite_mem_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awaddr = 8'd0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = 32'd0;
  logic [4:0]  wstrb = 5'd0;
  logic        wvalid = 1'b0, wready;
  logic [2:0]  bresp;
  logic        bvalid, bready = 1'b1;
  logic [7:0]  araddr = 8'd0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid, rready = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // Write with AW and W in the same cycle; returns bresp (bounded waits)
  task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            output logic [2:0] resp);
    int k;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    k = 0;
    while (!(awready && wready) && k < 20) begin @(negedge clk); k++; end
    if (k == 20) begin n_total++; $display("FAIL write_ready_timeout addr=%0d", a); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    if (k == 20) begin n_total++; $display("FAIL bvalid_timeout addr=%0d", a); end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic read_word(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    int k;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) begin n_total++; $display("FAIL arready_timeout addr=%0d", a); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!rvalid && k < 20) begin @(negedge clk); k++; end
    if (k == 20) begin n_total++; $display("FAIL rvalid_timeout addr=%0d", a); end
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000 || rdata !== 32'd0 || bresp !== 3'd0 || rresp !== 3'd0)
      $display("FAIL reset_hold got rdy/val=%b rdata=%h bresp=%0d rresp=%0d expected all 0",
               {awready, wready, arready, bvalid, rvalid}, rdata, bresp, rresp);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100)
      $display("FAIL reset_release got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
    else n_pass++;
  endtask

  task automatic test_basic();
    @(negedge clk);
    awaddr = 8'd16; awvalid = 1'b1; wdata = 32'd37; wstrb = 5'h0F; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bvalid !== 1'b1 || bresp !== 3'd0 || awready !== 1'b0 || wready !== 1'b0)
      $display("FAIL basic_bresp got bvalid=%b bresp=%0d aw=%b w=%b expected 1 0 0 0", bvalid, bresp, awready, wready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1)
      $display("FAIL basic_b_done got bvalid=%b aw=%b w=%b expected 0 1 1", bvalid, awready, wready);
    else n_pass++;
    araddr = 8'd16; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (rvalid !== 1'b1 || rdata !== 32'd37 || rresp !== 3'd0 || arready !== 1'b0)
      $display("FAIL basic_read got rvalid=%b rdata=%0d rresp=%0d arready=%b expected 1 37 0 0", rvalid, rdata, rresp, arready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rvalid !== 1'b0 || arready !== 1'b1)
      $display("FAIL basic_r_done got rvalid=%b arready=%b expected 0 1", rvalid, arready);
    else n_pass++;
  endtask

  task automatic test_split_write();
    logic [31:0] d; logic [2:0] r;
    @(negedge clk);
    wdata = 32'hAABBCCDD; wstrb = 5'b00101; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wdata = 32'h0; wstrb = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0)
        $display("FAIL split_wait%0d got wready=%b awready=%b bvalid=%b expected 0 1 0", i, wready, awready, bvalid);
      else n_pass++;
    end
    awaddr = 8'd4; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bvalid !== 1'b1 || bresp !== 3'd0 || wready !== 1'b0)
      $display("FAIL split_bresp got bvalid=%b bresp=%0d wready=%b expected 1 0 0", bvalid, bresp, wready);
    else n_pass++;
    @(posedge clk); #1;
    read_word(8'd4, d, r);
    n_total++;
    if (d !== 32'h00BB00DD || r !== 3'd0)
      $display("FAIL split_read got %h/%0d expected 00bb00dd/0", d, r);
    else n_pass++;
  endtask

  task automatic test_out_of_window();
    logic [31:0] d; logic [2:0] r;
    write_word(8'd64, 32'hFFFFFFFF, 5'h0F, r);
    n_total++;
    if (r !== 3'd2) $display("FAIL oow_bresp got %0d expected 2", r); else n_pass++;
    read_word(8'd0, d, r);
    n_total++;
    if (d !== 32'd0 || r !== 3'd0) $display("FAIL oow_word0 got %h/%0d expected 0/0", d, r); else n_pass++;
    read_word(8'd16, d, r);
    n_total++;
    if (d !== 32'd37) $display("FAIL oow_word4 got %h expected 25", d); else n_pass++;
    read_word(8'd200, d, r);
    n_total++;
    if (d !== 32'd0 || r !== 3'd2) $display("FAIL oow_read got %h/%0d expected 0/2", d, r); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [31:0] d; logic [2:0] r;
    write_word(8'd60, 32'hCAFEF00D, 5'h0F, r);
    n_total++;
    if (r !== 3'd0) $display("FAIL last_word_bresp got %0d expected 0", r); else n_pass++;
    write_word(8'd61, 32'h00000000, 5'h10, r);
    n_total++;
    if (r !== 3'd0) $display("FAIL zero_strb_bresp got %0d expected 0", r); else n_pass++;
    read_word(8'd63, d, r);
    n_total++;
    if (d !== 32'hCAFEF00D || r !== 3'd0) $display("FAIL unaligned_read got %h/%0d expected cafef00d/0", d, r); else n_pass++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 8'd8; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 5'h0F; wvalid = 1'b1;
    araddr = 8'd4; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (bvalid !== 1'b1 || bresp !== 3'd0 || awready !== 1'b0 || wready !== 1'b0)
        $display("FAIL stall_b%0d got bvalid=%b bresp=%0d aw=%b w=%b expected 1 0 0 0", i, bvalid, bresp, awready, wready);
      else n_pass++;
      n_total++;
      if (rvalid !== 1'b1 || rdata !== 32'h00BB00DD || rresp !== 3'd0 || arready !== 1'b0)
        $display("FAIL stall_r%0d got rvalid=%b rdata=%h rresp=%0d ar=%b expected 1 00bb00dd 0 0", i, rvalid, rdata, rresp, arready);
      else n_pass++;
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111)
      $display("FAIL stall_release got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [2:0] r;
    write_word(8'd12, 32'd7, 5'h0F, r);
    @(negedge clk);
    awaddr = 8'd12; awvalid = 1'b1; wdata = 32'd9; wstrb = 5'h0F; wvalid = 1'b1;
    araddr = 8'd12; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (rvalid !== 1'b1 || rdata !== 32'd7 || bvalid !== 1'b1)
      $display("FAIL collision_old got rvalid=%b rdata=%0d bvalid=%b expected 1 7 1", rvalid, rdata, bvalid);
    else n_pass++;
    @(posedge clk); #1;
    read_word(8'd12, d, r);
    n_total++;
    if (d !== 32'd9) $display("FAIL collision_new got %0d expected 9", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [2:0] r;
    @(negedge clk);
    rready = 1'b0;
    awaddr = 8'd20; awvalid = 1'b1;
    araddr = 8'd16; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111)
      $display("FAIL midreset_state got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    else n_pass++;
    wdata = 32'h55; wstrb = 5'h0F; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1)
      $display("FAIL midreset_w_alone got bvalid=%b wready=%b awready=%b expected 0 0 1", bvalid, wready, awready);
    else n_pass++;
    awaddr = 8'd24; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bvalid !== 1'b1 || bresp !== 3'd0) $display("FAIL midreset_b got %b/%0d expected 1/0", bvalid, bresp); else n_pass++;
    @(posedge clk); #1;
    read_word(8'd20, d, r);
    n_total++;
    if (d !== 32'd0) $display("FAIL midreset_stale_addr got %h expected 0", d); else n_pass++;
    read_word(8'd24, d, r);
    n_total++;
    if (d !== 32'h55) $display("FAIL midreset_new_addr got %h expected 55", d); else n_pass++;
    read_word(8'd16, d, r);
    n_total++;
    if (d !== 32'd0) $display("FAIL midreset_mem_cleared got %h expected 0", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_write();
    test_out_of_window();
    test_boundary();
    test_stall();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
